serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial multi-bit adder, the stage directly downstream of the 1-bit full_adder cell.
- Instantiates one full_adder and processes one bit per clock, LSB first, with a registered carry chained between cycles.
- Accepts two WIDTH-bit operands plus carry-in on a start pulse and returns a WIDTH-bit sum, carry-out and a one-cycle done pulse.
- Provides area-cheap addition for datapaths that can tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured when start is accepted.
- b_in  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse: sum_out/cout valid and newly updated.
- sum_out  output  WIDTH  registered sum, held until the next completion.
- cout  output  1  registered carry-out, held until the next completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state=IDLE, busy=0, done=0, sum_out=0, cout=0, internal shift registers=0, carry=0, bit counter=0.
- Reset has priority over all other inputs in every state.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0 loads a_sh<=a_in, b_sh<=b_in, carry<=cin, cnt<=0, then goes to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, at each edge:
  - The full_adder takes a_sh[0], b_sh[0] and carry.
  - Its sum bit shifts into the MSB of r_sh (r_sh right-shifts).
  - carry<=full_adder cout.
  - a_sh and b_sh right-shift with zero fill.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge (the WIDTH-th bit is processed), go to DONE on the same edge.
  - At that edge sum_out<=final r_sh value (including the bit just computed) and cout<=final carry.
- DONE: done=1 for exactly one cycle, then go to IDLE at the next edge unconditionally.
- Latency:
  - start accepted at E0 gives done high in the cycle following edge E_WIDTH.
  - For WIDTH=8, done is visible 8 cycles after the start edge.
  - Issue rate is one operation per WIDTH+2 cycles.
- Arithmetic: {cout,sum_out} = a_in + b_in + cin, computed modulo 2^(WIDTH+1). There is no overflow flag.
- Start handling:
  - start is ignored in SHIFT and DONE. It is not queued, and operands are not re-sampled.
  - Changes on a_in, b_in or cin after acceptance have no effect.
- Output stability: sum_out/cout change only on the edge entering DONE (or on reset). They hold the previous result throughout SHIFT.
- Output decoding: busy = (state==SHIFT) and done = (state==DONE), both decoded from registered state. Outputs have no combinational path from inputs.
- Counter width: clog2(WIDTH)+1 bits.
- WIDTH=1: SHIFT lasts one cycle and the counter compare is against 0.
- Reset mid-SHIFT:
  - The operation is aborted and the FSM goes to IDLE.
  - sum_out and cout are cleared to 0.
  - No done pulse is produced.
- start asserted in the same cycle as reset: reset wins and start is dropped.

Test Plan:
- Reset: hold reset 2 cycles with start=1 -> busy=0, done=0, sum_out=0, cout=0, FSM stays in IDLE.
- Basic add: WIDTH=8, a_in=8'h3C, b_in=8'h05, cin=0, one-cycle start -> busy high 8 cycles, then done one cycle, sum_out=8'h41, cout=0. A check 20 cycles later still reads 8'h41.
- Full carry ripple: a_in=8'hFF, b_in=8'h01, cin=0 -> sum_out=8'h00, cout=1. Then a_in=0, b_in=0, cin=1 -> sum_out=8'h01, cout=0.
- Ignored start: start at E0 with 8'h10+8'h20, change operands to 8'hAA/8'h55 and pulse start at E3 -> single done at E8, sum_out=8'h30, no second done.
- Reset mid-op: start 8'h7F+8'h01, assert reset at E4 for one cycle -> no done, sum_out=0. A new start with 8'h02+8'h03 then yields 8'h05 after 8 cycles.
- Exhaustive sweep: WIDTH=4, all 512 combinations of a_in, b_in and cin, each started in IDLE -> {cout,sum_out} equals a+b+cin every time, done pulses exactly once per operation.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell processes one bit per clock, LSB first,
// with the carry registered between cycles. Result and carry-out are held until the next completion.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last  = (cnt == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
  assign r_nxt = WIDTH'({fa_s, r_sh} >> 1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags registered from the next state so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == SHIFT);
      done <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      r_sh    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_nxt;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_out <= r_nxt;
            cout    <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus random ops at WIDTH=8
// and an exhaustive WIDTH=4 sweep, checked against plain integer addition.

module tb_serial_adder;
  logic       clk = 1'b0;
  logic       reset;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4)
  );

  // Runs one WIDTH=8 operation; scrambles operands right after acceptance.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output logic [8:0] res, output int lat, output int busy_n,
                        output bit held);
    logic [8:0] prev;
    prev = {cout8, sum8};
    held = 1'b1;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 0; busy_n = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) busy_n++;
      if ({cout8, sum8} !== prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = {cout8, sum8};
  endtask

  task automatic test_reset;
    reset = 1'b1; start8 = 1'b1; start4 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      failures++;
      $display("FAIL reset_w8: got busy=%b done=%b cout=%b sum=%h, want all 0", busy8, done8, cout8, sum8);
    end
    checks++;
    if ({busy4, done4, cout4, sum4} !== 7'd0) begin
      failures++;
      $display("FAIL reset_w4: got busy=%b done=%b cout=%b sum=%h, want all 0", busy4, done4, cout4, sum4);
    end
    reset = 1'b0; start8 = 1'b0; start4 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_dropped: got busy8=%b busy4=%b, want 0 0", busy8, busy4);
    end
  endtask

  task automatic test_basic;
    logic [8:0] res; int lat, bn; bit held;
    do_op8(8'h3C, 8'h05, 1'b0, res, lat, bn, held);
    checks++;
    if (res !== 9'h041) begin
      failures++; $display("FAIL basic_sum: got %h, want 041", res);
    end
    checks++;
    if (lat !== 8 || bn !== 8) begin
      failures++; $display("FAIL basic_latency: got lat=%0d busy=%0d, want 8 8", lat, bn);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++; $display("FAIL basic_done_pulse: got done=%b busy=%b, want 0 0", done8, busy8);
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({cout8, sum8} !== 9'h041) begin
      failures++; $display("FAIL basic_hold: got %h, want 041", {cout8, sum8});
    end
  endtask

  task automatic test_ripple;
    logic [8:0] res; int lat, bn; bit held;
    do_op8(8'hFF, 8'h01, 1'b0, res, lat, bn, held);
    checks++;
    if (res !== 9'h100) begin
      failures++; $display("FAIL ripple_ff_01: got %h, want 100", res);
    end
    @(negedge clk);
    do_op8(8'h00, 8'h00, 1'b1, res, lat, bn, held);
    checks++;
    if (res !== 9'h001) begin
      failures++; $display("FAIL ripple_cin_only: got %h, want 001", res);
    end
    checks++;
    if (!held) begin
      failures++; $display("FAIL ripple_hold_during_shift: got changed output, want previous result held");
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int lat, extra;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;                 // after E0
    @(negedge clk);                                // after E1
    @(negedge clk);                                // after E2
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;                 // after E3
    lat = 3;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    checks++;
    if (lat !== 8 || {cout8, sum8} !== 9'h030) begin
      failures++; $display("FAIL ignored_start: got lat=%0d res=%h, want 8 030", lat, {cout8, sum8});
    end
    extra = 0;
    repeat (14) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      failures++; $display("FAIL ignored_start_no_second_op: got %0d active cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] res; int lat, bn, seen; bit held;
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);                     // after E3
    reset = 1'b1;
    @(negedge clk);                                // after E4
    reset = 1'b0;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid_clear: got busy=%b done=%b res=%h, want 0 0 000", busy8, done8, {cout8, sum8});
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || {cout8, sum8} !== 9'h000) begin
      failures++; $display("FAIL reset_mid_no_done: got dones=%0d res=%h, want 0 000", seen, {cout8, sum8});
    end
    do_op8(8'h02, 8'h03, 1'b0, res, lat, bn, held);
    checks++;
    if (res !== 9'h005 || lat !== 8) begin
      failures++; $display("FAIL reset_mid_recover: got res=%h lat=%0d, want 005 8", res, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [8:0] res, exp_r; int lat, bn; bit held;
    logic [7:0] a, b; logic c;
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp_r = 9'(a) + 9'(b) + 9'(c);
      do_op8(a, b, c, res, lat, bn, held);
      checks++;
      if (res !== exp_r || lat !== 8 || bn !== 8 || !held) begin
        failures++;
        $display("FAIL random_%0d: %h+%h+%b got res=%h lat=%0d busy=%0d held=%b, want %h 8 8 1",
                 i, a, b, c, res, lat, bn, held, exp_r);
      end
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_sweep4;
    int lat, dn, bad;
    logic [4:0] exp_r;
    bad = 0;
    for (int v = 0; v < 512; v++) begin
      @(negedge clk);
      a4 = 4'(v); b4 = 4'(v >> 4); cin4 = 1'(v >> 8); start4 = 1'b1;
      exp_r = 5'(v & 15) + 5'((v >> 4) & 15) + 5'((v >> 8) & 1);
      @(negedge clk);
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
      lat = 0;
      while (done4 !== 1'b1 && lat < 20) begin
        @(negedge clk); lat++;
      end
      dn = (done4 === 1'b1) ? 1 : 0;
      @(negedge clk);
      if (done4 === 1'b1) dn++;
      checks++;
      if ({cout4, sum4} !== exp_r || lat !== 4 || dn !== 1) begin
        failures++; bad++;
        if (bad <= 10)
          $display("FAIL sweep4 v=%0d: got res=%h lat=%0d dones=%0d, want %h 4 1",
                   v, {cout4, sum4}, lat, dn, exp_r);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_ignored_start();
    test_reset_mid();
    test_random();
    test_sweep4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
